// File: rtl/player_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module : player_input_ctrl
// Brief  : Debounced next/prev/select front end with a cursor that skips
//          occupied cells; issues move and restart requests to game_fsm.
// Rev    : 1.0 - initial release
// ============================================================================
module player_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DB_W            = 3,
    parameter int TIMEOUT_CYCLES  = 32,
    parameter int TO_W            = 6,
    parameter int RESTART_HOLD    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_next,
    input  logic        btn_prev,
    input  logic        btn_sel,
    input  logic [17:0] cell_position,
    input  logic        player_turn,
    input  logic [1:0]  winner,
    input  logic [3:0]  move_cnt,
    output logic [3:0]  p_tick,
    output logic        p_confirm,
    output logic        cursor_valid,
    output logic        move_rejected
);

    localparam int c_NUM_BTN  = 3;
    localparam int c_BTN_NEXT = 0;
    localparam int c_BTN_PREV = 1;
    localparam int c_BTN_SEL  = 2;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_CONFIRM     = 3'd1,
        S_WAIT_ACCEPT = 3'd2,
        S_RESTART     = 3'd3,
        S_WAIT_CLEAR  = 3'd4
    } state_t;

    logic [c_NUM_BTN-1:0] w_raw;
    logic [c_NUM_BTN-1:0] r_sync1;
    logic [c_NUM_BTN-1:0] r_sync2;
    logic [c_NUM_BTN-1:0] w_evt;

    assign w_raw = {btn_sel, btn_prev, btn_next};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    generate
        for (genvar g = 0; g < c_NUM_BTN; g++) begin : g_btn
            logic [DB_W-1:0] r_db_cnt;
            logic [DB_W-1:0] w_db_inc;
            logic            r_level;
            logic            r_evt;

            assign w_db_inc = r_db_cnt + 1'b1;
            assign w_evt[g] = r_evt;

            // Only a press (accepted 0->1) raises an event; releases are silent.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_db_cnt <= '0;
                    r_level  <= 1'b0;
                    r_evt    <= 1'b0;
                end else begin
                    r_evt <= 1'b0;
                    if (r_sync2[g] == r_level) begin
                        r_db_cnt <= '0;
                    end else if (w_db_inc == DB_W'(DEBOUNCE_CYCLES)) begin
                        r_db_cnt <= '0;
                        r_level  <= r_sync2[g];
                        r_evt    <= r_sync2[g];
                    end else begin
                        r_db_cnt <= w_db_inc;
                    end
                end
            end
        end
    endgenerate

    logic [15:0] w_empty;
    logic [3:0]  w_fwd;
    logic [3:0]  w_bwd;

    always_comb begin
        w_empty = '0;
        for (int i = 0; i < 9; i++) begin
            w_empty[i] = (cell_position[2*i +: 2] == 2'b00);
        end
    end

    assign cursor_valid = w_empty[p_tick];

    // Scan farthest offset first so the nearest empty cell is the last one written.
    always_comb begin
        logic [4:0] v_f;
        logic [4:0] v_b;
        w_fwd = p_tick;
        w_bwd = p_tick;
        for (int k = 8; k >= 1; k--) begin
            v_f = {1'b0, p_tick} + 5'(k);
            if (v_f >= 5'd9) v_f = v_f - 5'd9;
            if (w_empty[v_f[3:0]]) w_fwd = v_f[3:0];
            v_b = {1'b0, p_tick} + 5'd9 - 5'(k);
            if (v_b >= 5'd9) v_b = v_b - 5'd9;
            if (w_empty[v_b[3:0]]) w_bwd = v_b[3:0];
        end
    end

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_latch;
    logic [3:0]      w_latch_nxt;
    logic [TO_W-1:0] r_cnt;
    logic [TO_W-1:0] w_cnt_nxt;
    logic [TO_W-1:0] w_cnt_inc;
    logic [3:0]      w_tick_nxt;
    logic            w_confirm_nxt;
    logic            w_rej_nxt;

    assign w_cnt_inc = r_cnt + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_latch_nxt = r_latch;
        w_cnt_nxt   = '0;
        w_tick_nxt  = p_tick;
        w_rej_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_evt[c_BTN_SEL]) begin
                    if (winner != 2'b00) begin
                        w_state_nxt = S_RESTART;
                    end else if (player_turn && cursor_valid) begin
                        w_state_nxt = S_CONFIRM;
                        w_latch_nxt = move_cnt;
                    end
                end else if (w_evt[c_BTN_NEXT] && !w_evt[c_BTN_PREV]) begin
                    w_tick_nxt = w_fwd;
                end else if (w_evt[c_BTN_PREV] && !w_evt[c_BTN_NEXT]) begin
                    w_tick_nxt = w_bwd;
                end
            end
            S_CONFIRM: begin
                w_state_nxt = S_WAIT_ACCEPT;
            end
            S_WAIT_ACCEPT: begin
                // Acceptance is checked before the timeout so a tie counts as accepted.
                if ((move_cnt != r_latch) || !player_turn) begin
                    w_state_nxt = S_IDLE;
                end else if (w_cnt_inc == TO_W'(TIMEOUT_CYCLES)) begin
                    w_state_nxt = S_IDLE;
                    w_rej_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_RESTART: begin
                if (r_cnt == TO_W'(RESTART_HOLD - 1)) begin
                    w_state_nxt = S_WAIT_CLEAR;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_WAIT_CLEAR: begin
                if (winner == 2'b00) begin
                    w_state_nxt = S_IDLE;
                    w_tick_nxt  = 4'd0;
                end else if (w_cnt_inc == TO_W'(TIMEOUT_CYCLES)) begin
                    w_state_nxt = S_IDLE;
                    w_rej_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_confirm_nxt = (w_state_nxt == S_CONFIRM) || (w_state_nxt == S_RESTART);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_latch       <= '0;
            r_cnt         <= '0;
            p_tick        <= '0;
            p_confirm     <= 1'b0;
            move_rejected <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_latch       <= w_latch_nxt;
            r_cnt         <= w_cnt_nxt;
            p_tick        <= w_tick_nxt;
            p_confirm     <= w_confirm_nxt;
            move_rejected <= w_rej_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_player_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_player_input_ctrl
// Brief  : Directed self-checking bench for player_input_ctrl.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_player_input_ctrl;

    logic        clk;
    logic        rst;
    logic        btn_next;
    logic        btn_prev;
    logic        btn_sel;
    logic [17:0] cell_position;
    logic        player_turn;
    logic [1:0]  winner;
    logic [3:0]  move_cnt;
    logic [3:0]  p_tick;
    logic        p_confirm;
    logic        cursor_valid;
    logic        move_rejected;

    int total = 0;
    int bad   = 0;

    localparam logic [17:0] c_X_CELLS    = 18'b00_00_00_00_00_00_10_01_00;
    localparam logic [17:0] c_ONLY0      = 18'b01_01_01_01_01_01_01_01_00;
    localparam logic [17:0] c_FULL       = 18'b01_01_01_01_01_01_01_01_01;
    localparam logic [17:0] c_MOVE_CELLS = 18'b00_00_00_00_00_01_10_01_00;

    player_input_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .btn_next      (btn_next),
        .btn_prev      (btn_prev),
        .btn_sel       (btn_sel),
        .cell_position (cell_position),
        .player_turn   (player_turn),
        .winner        (winner),
        .move_cnt      (move_cnt),
        .p_tick        (p_tick),
        .p_confirm     (p_confirm),
        .cursor_valid  (cursor_valid),
        .move_rejected (move_rejected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic press(input bit fwd);
        if (fwd) btn_next = 1'b1;
        else     btn_prev = 1'b1;
        tick(10);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        tick(8);
    endtask

    // Press select and watch n cycles; optional move_cnt bump and winner clear.
    task automatic run_sel(input int bump_at, input int clear_at, input int n,
                           input logic [3:0] exp_tick,
                           output int conf_first, output int conf_cnt,
                           output int rej_first, output int rej_cnt,
                           output int tick_bad);
        conf_first = 0; conf_cnt = 0; rej_first = 0; rej_cnt = 0; tick_bad = 0;
        btn_sel = 1'b1;
        for (int i = 1; i <= n; i++) begin
            tick(1);
            if (i == 10) btn_sel = 1'b0;
            if (i == bump_at) move_cnt = move_cnt + 4'd1;
            if (i == clear_at) winner = 2'b00;
            if (p_confirm) begin
                if (conf_first == 0) conf_first = i;
                conf_cnt++;
                if (p_tick !== exp_tick) tick_bad++;
            end
            if (move_rejected) begin
                if (rej_first == 0) rej_first = i;
                rej_cnt++;
            end
        end
    endtask

    initial begin
        int cf, cc, rf, rc, tb, first, cnt;

        rst = 1'b1; btn_next = 1'b0; btn_prev = 1'b0; btn_sel = 1'b0;
        cell_position = '0; player_turn = 1'b0; winner = 2'b00; move_cnt = 4'd0;
        tick(3);
        chk("reset_p_tick", 32'(p_tick), 0);
        chk("reset_p_confirm", 32'(p_confirm), 0);
        chk("reset_move_rejected", 32'(move_rejected), 0);
        chk("reset_cursor_valid", 32'(cursor_valid), 1);
        rst = 1'b0;
        tick(2);

        // Short bounce never reaches the debounce threshold.
        btn_next = 1'b1; tick(2); btn_next = 1'b0; tick(10);
        chk("bounce_p_tick", 32'(p_tick), 0);

        // Held press: event after sync+debounce, cursor moves the next cycle.
        first = 0;
        btn_next = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            if (p_tick == 4'd1 && first == 0) first = i;
        end
        btn_next = 1'b0;
        tick(8);
        chk("held_latency", 32'(first), 7);
        chk("held_single_step", 32'(p_tick), 1);

        press(1'b0);
        chk("prev_to_0", 32'(p_tick), 0);

        cell_position = c_X_CELLS;
        press(1'b1);
        chk("skip_next_to_3", 32'(p_tick), 3);
        press(1'b0);
        chk("skip_prev_to_0", 32'(p_tick), 0);
        press(1'b0);
        chk("wrap_prev_to_8", 32'(p_tick), 8);
        press(1'b1);
        chk("wrap_next_to_0", 32'(p_tick), 0);

        cell_position = c_ONLY0;
        press(1'b1);
        chk("only0_next_stays", 32'(p_tick), 0);
        press(1'b0);
        chk("only0_prev_stays", 32'(p_tick), 0);
        chk("only0_cursor_valid", 32'(cursor_valid), 1);
        cell_position = c_FULL;
        #1;
        chk("full_cursor_valid", 32'(cursor_valid), 0);

        // Accepted move.
        cell_position = c_MOVE_CELLS;
        tick(1);
        press(1'b1);
        chk("move_cursor_to_4", 32'(p_tick), 4);
        player_turn = 1'b1; winner = 2'b00; move_cnt = 4'd0;
        run_sel(12, 0, 50, 4'd4, cf, cc, rf, rc, tb);
        chk("move_conf_first", 32'(cf), 7);
        chk("move_conf_cnt", 32'(cc), 1);
        chk("move_tick_stable", 32'(tb), 0);
        chk("move_no_reject", 32'(rc), 0);

        // Not the player's turn: select dropped.
        player_turn = 1'b0;
        run_sel(0, 0, 50, 4'd4, cf, cc, rf, rc, tb);
        chk("noturn_conf_cnt", 32'(cc), 0);
        chk("noturn_no_reject", 32'(rc), 0);

        // Move never acknowledged.
        player_turn = 1'b1;
        run_sel(0, 0, 50, 4'd4, cf, cc, rf, rc, tb);
        chk("rej_conf_cnt", 32'(cc), 1);
        chk("rej_first", 32'(rf), 40);
        chk("rej_cnt", 32'(rc), 1);
        press(1'b1);
        chk("after_rej_next", 32'(p_tick), 5);

        // Restart after game over.
        winner = 2'b01;
        run_sel(0, 20, 50, 4'd5, cf, cc, rf, rc, tb);
        chk("restart_conf_first", 32'(cf), 7);
        chk("restart_conf_cnt", 32'(cc), 3);
        chk("restart_tick_stable", 32'(tb), 0);
        chk("restart_no_reject", 32'(rc), 0);
        chk("restart_tick_cleared", 32'(p_tick), 0);

        run_sel(12, 0, 50, 4'd0, cf, cc, rf, rc, tb);
        chk("post_restart_conf_first", 32'(cf), 7);
        chk("post_restart_conf_cnt", 32'(cc), 1);
        chk("post_restart_no_reject", 32'(rc), 0);

        // Async reset while a restart request is being held.
        press(1'b1);
        chk("pre_reset_tick", 32'(p_tick), 4);
        winner = 2'b01;
        btn_sel = 1'b1;
        tick(8);
        chk("pre_reset_confirm", 32'(p_confirm), 1);
        rst = 1'b1;
        btn_sel = 1'b0;
        #1;
        chk("async_reset_confirm", 32'(p_confirm), 0);
        chk("async_reset_tick", 32'(p_tick), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (p_confirm) cnt++;
        end
        chk("post_reset_no_confirm", 32'(cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
